// File: rtl/uart_stream_xcvr.sv
// uart_stream_xcvr: parametrised full-duplex UART with TX/RX FIFOs behind valid/ready streams.
// Define UART_LOOPBACK_EN to add the loopback port (RX fed from internal TX bit, ser_tx held high).
module uart_stream_xcvr #(
  parameter int CLKS_PER_BIT = 4167,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
`ifdef UART_LOOPBACK_EN
  input  logic                 loopback,
`endif
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  input  logic                 tx_clear_req,
  output logic                 ser_tx,
  input  logic                 ser_rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  input  logic                 rx_ready,
  output logic                 rx_overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TA = $clog2(TX_DEPTH);
  localparam int RA = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic PODD = (PARITY == 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} st_t;
  logic [DATA_BITS-1:0] tmem [TX_DEPTH];
  logic [TA:0] twr_q, trd_q;
  st_t txs_q, txs_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [3:0] tbit_q, tbit_d;
  logic [DATA_BITS-1:0] tsh_q, tsh_d;
  logic tpar_q, tpar_d, ser_q, ser_d;
  logic tempty, tfull, tpush, tpop, ttick, tlast_stop, rx_in;
  assign tempty = twr_q == trd_q;
  assign tfull = (twr_q[TA] != trd_q[TA]) && (twr_q[TA-1:0] == trd_q[TA-1:0]);
  assign tx_ready = !tfull && !wb_rst_i;
  assign tpush = tx_valid && tx_ready && !tx_clear_req;
  assign tx_busy = (txs_q != IDLE) || !tempty;
  assign ttick = tcnt_q == LAST;
  assign tlast_stop = (txs_q == STOP) && ttick && (tbit_q == 4'(STOP_BITS - 1));
  assign tpop = !tempty && ((txs_q == IDLE) || tlast_stop);
`ifdef UART_LOOPBACK_EN
  assign ser_tx = loopback | ser_q;
  assign rx_in = loopback ? ser_q : ser_rx;
`else
  assign ser_tx = ser_q;
  assign rx_in = ser_rx;
`endif
  always_ff @(posedge wb_clk_i)
    if (tpush) tmem[twr_q[TA-1:0]] <= tx_data;
  always_comb begin
    txs_d = txs_q;
    tcnt_d = ttick ? '0 : tcnt_q + 1'b1;
    tbit_d = tbit_q;
    tsh_d = tsh_q;
    tpar_d = tpar_q;
    case (txs_q)
      IDLE: tcnt_d = '0;
      START: if (ttick) txs_d = DATA;
      DATA: if (ttick) begin
        tsh_d = tsh_q >> 1;
        tbit_d = (tbit_q == 4'(DATA_BITS - 1)) ? '0 : tbit_q + 1'b1;
        if (tbit_q == 4'(DATA_BITS - 1)) txs_d = (PARITY != 0) ? PAR : STOP;
      end
      PAR: if (ttick) txs_d = STOP;
      STOP: if (ttick) begin
        tbit_d = tbit_q + 1'b1;
        if (tlast_stop) txs_d = IDLE;
      end
      default: txs_d = IDLE;
    endcase
    if (tpop) begin
      txs_d = START;
      tcnt_d = '0;
      tbit_d = '0;
      tsh_d = tmem[trd_q[TA-1:0]];
      tpar_d = ^tmem[trd_q[TA-1:0]] ^ PODD;
    end
    ser_d = (txs_q == START) ? 1'b0 : (txs_q == DATA) ? tsh_q[0] : (txs_q == PAR) ? tpar_q : 1'b1;
  end
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      twr_q <= '0;
      trd_q <= '0;
      txs_q <= IDLE;
      tcnt_q <= '0;
      tbit_q <= '0;
      tsh_q <= '0;
      tpar_q <= 1'b0;
      ser_q <= 1'b1;
    end else begin
      twr_q <= twr_q + (TA+1)'(tpush);
      trd_q <= tx_clear_req ? twr_q : trd_q + (TA+1)'(tpop);
      txs_q <= txs_d;
      tcnt_q <= tcnt_d;
      tbit_q <= tbit_d;
      tsh_q <= tsh_d;
      tpar_q <= tpar_d;
      ser_q <= ser_d;
    end
  // RX: 2-FF synchroniser plus previous-sample register for start-edge detection
  logic rs1_q, rs2_q, rprev_q;
  st_t rxs_q, rxs_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [3:0] rbit_q, rbit_d;
  logic [DATA_BITS-1:0] rsh_q, rsh_d;
  logic rperr_q, rperr_d, rpush, rtick, rempty, rfull, rpop, rwr_en, ovr_q;
  logic [DATA_BITS+1:0] rmem [RX_DEPTH];
  logic [DATA_BITS+1:0] rhead;
  logic [RA:0] rwr_q, rrd_q;
  assign rtick = rcnt_q == LAST;
  assign rempty = rwr_q == rrd_q;
  assign rfull = (rwr_q[RA] != rrd_q[RA]) && (rwr_q[RA-1:0] == rrd_q[RA-1:0]);
  assign rx_valid = !rempty;
  assign rpop = rx_valid && rx_ready;
  assign rwr_en = rpush && (!rfull || rpop);
  assign rhead = rx_valid ? rmem[rrd_q[RA-1:0]] : '0;
  assign rx_data = rhead[DATA_BITS-1:0];
  assign rx_frame_err = rhead[DATA_BITS];
  assign rx_parity_err = rhead[DATA_BITS+1];
  assign rx_overrun = ovr_q;
  always_comb begin
    rxs_d = rxs_q;
    rcnt_d = rtick ? '0 : rcnt_q + 1'b1;
    rbit_d = rbit_q;
    rsh_d = rsh_q;
    rperr_d = rperr_q;
    rpush = 1'b0;
    case (rxs_q)
      IDLE: begin
        rcnt_d = '0;
        if (rprev_q && !rs2_q) rxs_d = START;
      end
      START: if (rcnt_q == HALF) begin
        rcnt_d = '0;
        rbit_d = '0;
        rperr_d = 1'b0;
        rxs_d = rs2_q ? IDLE : DATA;
      end
      DATA: if (rtick) begin
        rsh_d = {rs2_q, rsh_q[DATA_BITS-1:1]};
        rbit_d = rbit_q + 1'b1;
        if (rbit_q == 4'(DATA_BITS - 1)) rxs_d = (PARITY != 0) ? PAR : STOP;
      end
      PAR: if (rtick) begin
        rperr_d = (^rsh_q ^ rs2_q) != PODD;
        rxs_d = STOP;
      end
      STOP: if (rtick) begin
        rpush = 1'b1;
        rxs_d = IDLE;
      end
      default: rxs_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i)
    if (rwr_en) rmem[rwr_q[RA-1:0]] <= {rperr_q, !rs2_q, rsh_q};
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      rs1_q <= 1'b1;
      rs2_q <= 1'b1;
      rprev_q <= 1'b1;
      rxs_q <= IDLE;
      rcnt_q <= '0;
      rbit_q <= '0;
      rsh_q <= '0;
      rperr_q <= 1'b0;
      rwr_q <= '0;
      rrd_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      rs1_q <= rx_in;
      rs2_q <= rs1_q;
      rprev_q <= rs2_q;
      rxs_q <= rxs_d;
      rcnt_q <= rcnt_d;
      rbit_q <= rbit_d;
      rsh_q <= rsh_d;
      rperr_q <= rperr_d;
      rwr_q <= rwr_q + (RA+1)'(rwr_en);
      rrd_q <= rrd_q + (RA+1)'(rpop);
      ovr_q <= rpush && rfull && !rpop;
    end
endmodule
